// File: rtl/cgra_cfg_mem_arbiter_pkg.sv
// Shared types and requester IDs for the CGRA config/spike SRAM arbiter.
package cgra_arb_pkg;

   // Arbiter FSM states
   typedef enum logic {
      ARB   = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Requester slot assignment
   localparam int unsigned REQ_HOST = 0;
   localparam int unsigned REQ_CFG  = 1;
   localparam int unsigned REQ_DMA  = 2;

endpackage

// File: rtl/cgra_cfg_mem_arbiter_if.sv
// Requester-side bus of the CGRA SRAM arbiter: per-requester beats plus shared read return.
interface cgra_cfg_mem_arbiter_if #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 32
) ();

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_we;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_rdata;

   // Requester side (cfg/DMA engines, CSR host)
   modport master (
      output req_valid, req_we, req_last, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   // Arbiter side
   modport slave (
      input  req_valid, req_we, req_last, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/cgra_cfg_mem_arbiter_rr_picker.sv
// Rotating-priority encoder: first valid requester at or after ptr, cyclically.
module cgra_rr_picker #(
   parameter  int unsigned NUM_REQ = 3,
   localparam int unsigned GNT_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [GNT_W-1:0]   ptr,
   output logic [GNT_W-1:0]   winner,
   output logic               any
);

   int unsigned idx;

   // Scan NUM_REQ slots starting at ptr; the first hit wins
   always_comb begin
      winner = '0;
      any    = 1'b0;
      idx    = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(ptr) + k) % NUM_REQ;
         if (!any && valid[GNT_W'(idx)]) begin
            any    = 1'b1;
            winner = GNT_W'(idx);
         end
      end
   end

endmodule

// File: rtl/cgra_cfg_mem_arbiter.sv
// Single-port SRAM arbiter for the CGRA config/spike memory: round-robin,
// locked bursts capped at MAX_BURST beats, 1-cycle read return.
// Build option: CGRA_ARB_HOST_PRIO_EN gives requester 0 (CSR host) absolute
// priority in arbitration without moving the round-robin pointer.
module cgra_cfg_mem_arbiter
   import cgra_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ   = 3,
   parameter  int unsigned ADDR_W    = 16,
   parameter  int unsigned DATA_W    = 32,
   parameter  int unsigned MAX_BURST = 16,
   localparam int unsigned GNT_W     = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cgra_cfg_mem_arbiter_if.slave bus,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic [GNT_W-1:0]     grant_id,
   output logic                 arb_busy,
   output logic [31:0]          perf_conflicts
);

   localparam int unsigned BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   arb_state_t         state;
   logic [GNT_W-1:0]   rr_ptr;
   logic [BEAT_W-1:0]  beat_cnt;
   logic [GNT_W-1:0]   pick;
   logic               pick_any;
   logic [GNT_W-1:0]   winner;
   logic [GNT_W-1:0]   next_ptr;
   logic               in_grant;
   logic               own_valid;
   logic               hs;
   logic               release_now;

   cgra_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .valid  (bus.req_valid),
      .ptr    (rr_ptr),
      .winner (pick),
      .any    (pick_any)
   );

   // Winner selection, optionally overridden by the host
   always_comb begin
`ifdef CGRA_ARB_HOST_PRIO_EN
      winner = bus.req_valid[REQ_HOST] ? GNT_W'(REQ_HOST) : pick;
`else
      winner = pick;
`endif
   end

   assign in_grant    = (state == GRANT);
   assign own_valid   = bus.req_valid[grant_id];
   assign hs          = in_grant && own_valid;
   assign release_now = in_grant &&
                        (!own_valid || bus.req_last[grant_id] ||
                         (beat_cnt == BEAT_W'(MAX_BURST - 1)));
   assign next_ptr    = (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
   assign arb_busy    = in_grant;

   // Owner's beat drives the SRAM; only the owner sees ready
   always_comb begin
      bus.req_ready           = '0;
      bus.req_ready[grant_id] = in_grant;
      mem_en    = hs;
      mem_we    = hs && bus.req_we[grant_id];
      mem_addr  = bus.req_addr[32'(grant_id) * ADDR_W +: ADDR_W];
      mem_wdata = bus.req_wdata[32'(grant_id) * DATA_W +: DATA_W];
   end

   // Read data is forwarded straight from the macro in the response cycle
   assign bus.rsp_rdata = (|bus.rsp_valid) ? mem_rdata : '0;

   // Arbitration FSM, burst counting, read-response tag and conflict counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= ARB;
         rr_ptr         <= '0;
         grant_id       <= '0;
         beat_cnt       <= '0;
         perf_conflicts <= '0;
         bus.rsp_valid  <= '0;
      end else begin
         bus.rsp_valid <= '0;
         if (hs && !bus.req_we[grant_id]) begin
            bus.rsp_valid[grant_id] <= 1'b1;
         end
         unique case (state)
            ARB: begin
               if (($countones(bus.req_valid) >= 2) && (perf_conflicts != '1)) begin
                  perf_conflicts <= perf_conflicts + 32'd1;
               end
               if (pick_any) begin
                  grant_id <= winner;
                  beat_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (hs) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
               if (release_now) begin
                  state    <= ARB;
                  beat_cnt <= '0;
`ifdef CGRA_ARB_HOST_PRIO_EN
                  if (grant_id != GNT_W'(REQ_HOST)) begin
                     rr_ptr <= next_ptr;
                  end
`else
                  rr_ptr <= next_ptr;
`endif
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule

// File: doc/cgra_cfg_mem_arbiter.md
Name: cgra_cfg_mem_arbiter

Overview:
Arbitrates single-port access to the shared CGRA configuration/spike SRAM among three requesters: 0 = CSR host, 1 = config loader, 2 = DMA.
- Each grant is a locked burst bounded by MAX_BURST beats.
- Round-robin fairness across requesters.
- Read data returns with fixed 1-cycle SRAM latency.
- Sits between the control unit's cfg/DMA engines and the SRAM macro.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_W, 16, SRAM word address width
DATA_W, 32, SRAM data width
MAX_BURST, 16, max beats per grant before forced release (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester beat valid
req_we  in  NUM_REQ  per-requester write enable
req_last  in  NUM_REQ  marks final beat of requester's burst
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_ready  out  NUM_REQ  beat accepted when valid&&ready
rsp_valid  out  NUM_REQ  read data valid for requester i
rsp_rdata  out  DATA_W  shared read data bus
mem_en  out  1  SRAM enable
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  DATA_W  SRAM write data
mem_rdata  in  DATA_W  SRAM read data, valid 1 cycle after mem_en&&!mem_we
grant_id  out  $clog2(NUM_REQ)  current owner
arb_busy  out  1  high in GRANT
perf_conflicts  out  32  saturating count of arbitration cycles with >=2 valid requests

Behaviour:
- Reset values: state ARB, rr_ptr=0, grant_id=0, beat_cnt=0, perf_conflicts=0, rsp_valid=0, rsp_rdata=0. All req_ready=0, mem_en=0, mem_we=0.
- FSM, two states:
  - ARB: if any req_valid, winner = first valid requester at or after rr_ptr (cyclic). Register grant_id, go to GRANT, beat_cnt=0. No SRAM access in ARB.
  - GRANT: req_ready[grant_id]=1, others 0 (combinational).
    - mem_en = req_valid[grant_id]; mem_we/addr/wdata are muxed from grant_id.
    - Each handshake increments beat_cnt.
- Release from GRANT to ARB happens on whichever occurs first:
  - handshake with req_last;
  - handshake where beat_cnt == MAX_BURST-1 (forced release; requester re-arbitrates for the remainder);
  - req_valid[grant_id]==0 in GRANT (owner dropped; zero-beat grant allowed).
- On release: rr_ptr = grant_id+1, wrapping modulo NUM_REQ.
- Every ownership change passes through ARB: one idle SRAM cycle between bursts.
- Read return: rsp_valid[g] is pulsed the cycle after a read handshake by owner g, with rsp_rdata = mem_rdata. A response still completes if release happened on that beat. Writes produce no response.
- perf_conflicts increments in ARB when popcount(req_valid) >= 2. It saturates at 0xFFFFFFFF.
- Reset mid-burst: all of the above return to reset values next edge. A pending read response is dropped (rsp_valid=0).
- Non-owner valids are ignored: they are not accepted and not counted, and must stay stable until ready.

Optional Feature:
CGRA_ARB_HOST_PRIO_EN
- Defined: in ARB, requester 0 wins whenever req_valid[0]=1, regardless of rr_ptr. A grant to requester 0 does not update rr_ptr. Other requesters still use round-robin among themselves.
- Undefined: pure round-robin for all requesters.

Decomposition:
- Package cgra_arb_pkg: arb_state_t enum {ARB, GRANT}; requester ID localparams REQ_HOST=0, REQ_CFG=1, REQ_DMA=2.
- Sub-module cgra_rr_picker: combinational rotating-priority encoder taking (req_valid, rr_ptr) and producing (winner, any). Instantiated once.

Test Plan:
- Single DMA read burst, addr 0x0010..0x0013, req_last on 4th beat: 4 mem reads; rsp_valid[2] for 4 cycles, 1 cycle behind each beat; returns to ARB; rr_ptr=0.
- All three valid at once from reset, each 2-beat burst: grant order 0,1,2 with 1 idle cycle between bursts; perf_conflicts=2.
- Cfg loader 20-beat write, MAX_BURST=16: forced release after beat 16. Loader re-granted (other requesters idle), writes remaining 4; total 20 SRAM writes, 1 bubble.
- DMA owns bus while host also requests (macro undefined): host gets grant only after DMA's req_last. With CGRA_ARB_HOST_PRIO_EN and host+cfg+DMA pending with rr_ptr=1, host wins first.
- rst_n low on beat 2 of a read burst: next cycle all outputs at reset values, no rsp_valid for the dropped read.
- Owner drops req_valid mid-burst after 3 beats: release; a waiting requester is granted after 1 ARB cycle.
